// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared FSM states and timing constants for the UART RX controller.
package uart_rx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, ERR_CHK} rx_state_e;
    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;
    // Cycles after mid-bit until the sampler's majority vote has settled.
    localparam int CHK_OFF     = 2;
endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// uart_rx_edge_bit_cnt: oversample edge counter and bit counter with latched prescale.
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  ld,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic [PRESCALE_W-1:0] p,
    output logic                  wrap
);
    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d, p_q, p_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

    always_comb begin
        p_d        = ld ? prescale : p_q;
        wrap       = edge_cnt_q == p_q - 1'b1;
        edge_cnt_d = clr ? '0 : (en ? (wrap ? '0 : edge_cnt_q + 1'b1) : edge_cnt_q);
        bit_cnt_d  = clr ? '0 : ((en && wrap) ? bit_cnt_q + 1'b1 : bit_cnt_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            p_q        <= PRESCALE_W'(PRESCALE_16);
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            p_q        <= p_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;
    assign p        = p_q;
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART RX sequencer; start detect, bit timing, checker strobes and frame validation.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  rx_check_en,
    output logic                  data_valid,
    output logic                  busy,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt
);
    rx_state_e             state_q, state_d;
    logic                  data_valid_q, data_valid_d;
    logic [PRESCALE_W-1:0] p, half, chk_pt;
    logic                  wrap, idle, at_chk, cnt_clr;

    uart_rx_edge_bit_cnt #(
        .PRESCALE_W(PRESCALE_W),
        .BIT_CNT_W (BIT_CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .en      (!cnt_clr),
        .clr     (cnt_clr),
        .ld      (idle),
        .prescale(prescale),
        .edge_cnt(edge_cnt),
        .bit_cnt (bit_cnt),
        .p       (p),
        .wrap    (wrap)
    );

    always_comb begin
        half    = p >> 1;
        chk_pt  = half + PRESCALE_W'(CHK_OFF);
        idle    = state_q == IDLE;
        at_chk  = edge_cnt == chk_pt;
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = rx_in ? IDLE : START;
            START:   state_d = wrap ? (strt_glitch ? IDLE : DATA) : START;
            DATA:    state_d = (wrap && bit_cnt == BIT_CNT_W'(DATA_WIDTH)) ? (par_en ? PARITY : STOP) : DATA;
            PARITY:  state_d = wrap ? STOP : PARITY;
            // Leave the stop bit early so a back-to-back start edge is not missed.
            STOP:    state_d = (edge_cnt == chk_pt + 1'b1) ? ERR_CHK : STOP;
            ERR_CHK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_clr      = idle || state_d == IDLE;
        rx_check_en  = state_q == START && edge_cnt == '0;
        strt_chk_en  = state_q == START && at_chk;
        deser_en     = state_q == DATA && at_chk;
        par_chk_en   = state_q == PARITY && at_chk;
        stp_chk_en   = state_q == STOP && at_chk;
        dat_samp_en  = !idle && state_q != ERR_CHK && edge_cnt >= half - 1'b1 && edge_cnt <= half + 1'b1;
        data_valid_d = state_q == ERR_CHK && !(stp_err || (par_en && par_err));
        busy         = !idle;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign data_valid = data_valid_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench with checker responders and a frame-level timing model.
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;
    localparam int DW = 8;
    localparam int PW = 6;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst, rx_in, par_en;
    logic          strt_glitch = 1'b0, par_err = 1'b0, stp_err = 1'b0;
    logic [PW-1:0] prescale;
    logic          dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic          rx_check_en, data_valid, busy;
    logic [PW-1:0] edge_cnt;
    logic [BW-1:0] bit_cnt;

    int   tests = 0, fails = 0, cyc = 0, cur_p = 16;
    int   deser_n = 0, par_n = 0, stp_n = 0;
    logic cur_par = 1'b0, plan_glitch = 1'b0, plan_perr = 1'b0, plan_serr = 1'b0;

    typedef struct {int cyc; int par;} exp_t;
    exp_t exp_q[$];

    uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en), .prescale(prescale),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .dat_samp_en(dat_samp_en), .deser_en(deser_en), .strt_chk_en(strt_chk_en),
        .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .rx_check_en(rx_check_en),
        .data_valid(data_valid), .busy(busy), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Detect cycle to data_valid for an error-free frame.
    function automatic int frame_len(input int p, input int pe);
        return 1 + (DW + 1 + pe) * p + (p / 2 + 2) + 2 + 1;
    endfunction

    function automatic int all_outs();
        return int'({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
                     rx_check_en, data_valid, busy, edge_cnt, bit_cnt});
    endfunction

    // Checker stand-ins: flags cleared at frame start, loaded on their strobe.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        end else begin
            if (rx_check_en) begin
                strt_glitch = 1'b0; par_err = plan_perr & ~cur_par; stp_err = 1'b0;
            end
            if (strt_chk_en) strt_glitch = plan_glitch;
            if (par_chk_en) par_err = plan_perr;
            if (stp_chk_en) stp_err = plan_serr;
        end
    end

    initial forever begin
        logic [4:0] s;
        exp_t e;
        @(negedge clk);
        if (rst) begin
            s = {rx_check_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en};
            if (|s) chk("strobe_onehot", $countones(s), 1);
            if (rx_check_en) begin deser_n = 0; par_n = 0; stp_n = 0; end
            if (strt_chk_en) chk("strt_edge", int'(edge_cnt), cur_p / 2 + 2);
            if (deser_en) begin
                deser_n++;
                chk("deser_edge", int'(edge_cnt), cur_p / 2 + 2);
                chk("deser_bit", int'(bit_cnt >= 1 && bit_cnt <= DW), 1);
            end
            if (par_chk_en) begin par_n++; chk("par_edge", int'(edge_cnt), cur_p / 2 + 2); end
            if (stp_chk_en) begin stp_n++; chk("stp_edge", int'(edge_cnt), cur_p / 2 + 2); end
            chk("samp_window", int'(dat_samp_en),
                int'(busy && int'(edge_cnt) >= cur_p / 2 - 1 && int'(edge_cnt) <= cur_p / 2 + 1));
            if (data_valid) begin
                if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("valid_cycle", cyc, e.cyc);
                    chk("deser_count", deser_n, DW);
                    chk("par_count", par_n, e.par);
                    chk("stp_count", stp_n, 1);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input int p, input logic pe, input logic pr, input logic sr);
        prescale = PW'(p); par_en = pe; cur_p = p; cur_par = pe;
        plan_perr = pr; plan_serr = sr; plan_glitch = 1'b0;
        if (!sr && !(pe && pr)) exp_q.push_back('{cyc + frame_len(p, int'(pe)), int'(pe)});
        rx_in = 1'b0;
        repeat (p) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            rx_in = d[i];
            repeat (p) @(negedge clk);
        end
        if (pe) begin
            rx_in = ^d;
            repeat (p) @(negedge clk);
        end
        rx_in = 1'b1;
        repeat (p / 2 + 6) @(negedge clk);
    endtask

    task automatic glitch(input int p);
        prescale = PW'(p); cur_p = p; plan_glitch = 1'b1;
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        chk("glitch_busy_start", int'(busy), 1);
        repeat (p + 2) @(negedge clk);
        chk("glitch_idle", int'(busy), 0);
        chk("glitch_no_deser", deser_n, 0);
        plan_glitch = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; prescale = PW'(PRESCALE_16);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", all_outs(), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_outs", all_outs(), 0);

        send(8'hA5, PRESCALE_8, 1'b1, 1'b0, 1'b0);
        send(8'h3C, PRESCALE_16, 1'b0, 1'b0, 1'b0);
        send(8'h3C, PRESCALE_16, 1'b0, 1'b0, 1'b0);
        glitch(PRESCALE_16);
        send(8'h5A, PRESCALE_8, 1'b1, 1'b1, 1'b0);
        send(8'h81, PRESCALE_8, 1'b1, 1'b0, 1'b0);
        send(8'hF0, PRESCALE_32, 1'b0, 1'b0, 1'b1);
        send(8'h0F, PRESCALE_16, 1'b0, 1'b1, 1'b0);

        // Abort in bit 4 after a mid-frame prescale change, then run at the new rate.
        prescale = PW'(PRESCALE_16); par_en = 1'b0; cur_p = 16; cur_par = 1'b0;
        rx_in = 1'b0;
        repeat (16) @(negedge clk);
        rx_in = 1'b1;
        repeat (32) @(negedge clk);
        prescale = PW'(PRESCALE_8);
        repeat (24) @(negedge clk);
        chk("mid_bit", int'(bit_cnt), 4);
        #1 rst = 1'b0;
        #1 chk("reset_mid_outs", all_outs(), 0);
        @(negedge clk);
        rst = 1'b1;
        send(8'h96, PRESCALE_8, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 30; k++) begin
            int idx, p;
            idx = int'($urandom_range(0, 2));
            p = idx == 0 ? PRESCALE_8 : (idx == 1 ? PRESCALE_16 : PRESCALE_32);
            if ($urandom_range(0, 7) == 0) glitch(p);
            else send(8'($urandom), p, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
        chk("pending_frames", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
